uart_alarma_cmd: RTL and testbench
==================================

# uart_alarma_cmd

Serial command receiver that drives the alarm's setting interface. It deserializes 8N1 UART bytes from the host and parses ASCII commands. A valid set command produces a one-cycle `load` pulse with `ore_setare`/`minute_setare`; a valid stop command produces a one-cycle `stop` pulse. It sits between the board RX pin and the alarm block's `load`/`ore_setare`/`minute_setare`/`stop` inputs.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 8.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clock`.
- `ore_setare`  out  5  parsed hour, 0–23; held between loads.
- `minute_setare`  out  6  parsed minute, 0–59; held between loads.
- `load`  out  1  one-cycle pulse; a new valid time is on `ore_setare`/`minute_setare`.
- `stop`  out  1  one-cycle pulse on a valid stop command.
- `err`  out  1  one-cycle pulse on a framing error or malformed command.
- `busy`  out  1  high while a UART frame is being received.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value.
- Bit-level receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a sync high→low transition starts a frame; bit counter cleared.
  - START: wait `CLKS_PER_BIT/2` cycles and resample. If the sample is 1, it is a false start: return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - STOP: sample after `CLKS_PER_BIT` more cycles.
    - Sample 1: the byte is valid; pulse internal `byte_valid`.
    - Sample 0: framing error; pulse `err`, reset the parser to WAIT_CMD, and discard the byte.
  - Return to IDLE on the same cycle. A new start edge is accepted immediately afterwards.
- `busy` is high from the start-edge detect through the stop-bit sample cycle inclusive.
- Command formats, ASCII:
  - Set: `A` H1 H0 `:` M1 M0 CR(0x0D).
  - Stop: `S` CR.
- Parser FSM states: WAIT_CMD, H1, H0, COLON, M1, M0, END_SET, END_STOP. It consumes one byte per `byte_valid`.
  - WAIT_CMD: `A` → H1; `S` → END_STOP; LF (0x0A) and CR are ignored silently; any other byte → `err`, stay in WAIT_CMD.
  - H1: '0'–'2' accepted.
  - H0: '0'–'9' accepted, or '0'–'3' when H1 = '2'.
  - COLON: ':' accepted.
  - M1: '0'–'5' accepted.
  - M0: '0'–'9' accepted.
  - END_SET and END_STOP: CR accepted.
  - Any rejected byte in these states → `err` pulse and go to WAIT_CMD. The offending byte is consumed and not reinterpreted as a command.
- Digit conversion: subtract 0x30, then value = tens·10 + units.
  - Compute tens·10 as (tens<<3)+(tens<<1).
  - Hours use 5-bit arithmetic, minutes use 6-bit; ranges are pre-validated, so no overflow.
- Parsed digits are held in internal staging registers. `ore_setare`/`minute_setare` update only when CR is accepted in END_SET, so a partial or erroneous command never changes the outputs.
- `load` and `stop` are mutually exclusive. At most one of `load`/`stop`/`err` pulses per byte.
- `reset` low at any time, including mid-frame or mid-command, immediately forces:
  - both FSMs to IDLE/WAIT_CMD;
  - staging registers to 0;
  - `ore_setare`=0, `minute_setare`=0, `load`=0, `stop`=0, `err`=0, `busy`=0.

## Timing
- Sample points, with the start-edge detect cycle = 0:
  - start check at cycle `CLKS_PER_BIT/2`;
  - data bit k at `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`;
  - stop bit at `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`.
- `byte_valid` is asserted on the stop-sample cycle.
- `load`/`stop`/`err` from parsing are registered and high exactly one cycle, on the cycle after `byte_valid`. `ore_setare`/`minute_setare` are valid on that same cycle.
- A framing `err` is high on the cycle after the stop sample.
- Synchronizer latency of 2 cycles from pin to start detect. Total latency from the CR stop-bit midpoint on the pin to `load` is 3 cycles.
- Back-to-back frames with zero idle bits must be received without loss.

## Test plan
With `CLKS_PER_BIT`=16 in all cases.
- "A07:45\r" → one `load` pulse; `ore_setare`=7, `minute_setare`=45; no `err`.
- "A23:59\r" then "A00:00\r" back-to-back → two `load` pulses carrying 23/59 then 0/0; outputs hold 0/0 afterwards.
- "A24:10\r" → `err` pulse on the '4' byte, no `load`; the following bytes ":10\r" each produce `err` except "\r", which is ignored; outputs keep their prior values.
- "S\r" → one `stop` pulse, no `load`, and `ore_setare`/`minute_setare` unchanged.
- A 3-cycle low glitch on `rx` gives no `busy` beyond the false-start check and no `err`. A frame with stop bit = 0 gives an `err` pulse and a parser reset: "A1" + bad frame + "2:30\r" produces no `load`.
- `reset` asserted low during the M1 byte of "A12:34\r" → all outputs 0 immediately. After release, "A01:02\r" → `load` with 1/2.

Source files
------------

// File: rtl/uart_alarma_cmd.sv
// rtl/uart_alarma_cmd.sv - 8N1 UART receiver and ASCII command parser for alarm time set/stop
module uart_alarma_cmd #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [4:0] ore_setare,
  output logic [5:0] minute_setare,
  output logic       load,
  output logic       stop,
  output logic       err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_WAIT_CMD = 3'd0;
  localparam logic [2:0] P_H1       = 3'd1;
  localparam logic [2:0] P_H0       = 3'd2;
  localparam logic [2:0] P_COLON    = 3'd3;
  localparam logic [2:0] P_M1       = 3'd4;
  localparam logic [2:0] P_M0       = 3'd5;
  localparam logic [2:0] P_END_SET  = 3'd6;
  localparam logic [2:0] P_END_STOP = 3'd7;

  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;

  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic [2:0]       r_pstate;
  logic [3:0]       r_h1;
  logic [3:0]       r_h0;
  logic [3:0]       r_m1;
  logic [3:0]       r_m0;
  logic [4:0]       r_ore;
  logic [5:0]       r_min;
  logic             r_load;
  logic             r_stop;
  logic             r_err;

  logic             w_start_edge;
  logic             w_stop_sample;
  logic             w_byte_valid;
  logic             w_frame_err;
  logic [7:0]       w_byte;
  logic [3:0]       w_digit;
  logic             w_is_digit;
  logic [4:0]       w_h1x;
  logic [4:0]       w_hour;
  logic [5:0]       w_m1x;
  logic [5:0]       w_minute;

  assign w_start_edge  = (r_rx_state == RX_IDLE) && r_rx_prev && !r_rx_s2;
  assign w_stop_sample = (r_rx_state == RX_STOP) && (r_cnt == FULL_M1);
  assign w_byte_valid  = w_stop_sample && r_rx_s2;
  assign w_frame_err   = w_stop_sample && !r_rx_s2;
  assign w_byte        = r_shift;

  // ASCII digits are 0x30..0x39, so once validated the low nibble is the byte minus 0x30
  assign w_digit    = w_byte[3:0];
  assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);

  // tens*10 built from shifts; ranges are pre-checked so neither width overflows
  assign w_h1x    = {1'b0, r_h1};
  assign w_hour   = (w_h1x << 3) + (w_h1x << 1) + {1'b0, r_h0};
  assign w_m1x    = {2'b00, r_m1};
  assign w_minute = (w_m1x << 3) + (w_m1x << 1) + {2'b00, r_m0};

  assign busy          = (r_rx_state != RX_IDLE) || w_start_edge;
  assign ore_setare    = r_ore;
  assign minute_setare = r_min;
  assign load          = r_load;
  assign stop          = r_stop;
  assign err           = r_err;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Bit-level receiver: mid-bit sampling driven from the start-edge detect cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_start_edge) begin
            r_rx_state <= RX_START;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt      <= '0;
            // a line that is high again at mid-start was a glitch, not a frame
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == FULL_M1) begin
            r_cnt      <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Command parser: one byte per byte_valid, outputs committed only on the final CR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pstate <= P_WAIT_CMD;
      r_h1     <= 4'd0;
      r_h0     <= 4'd0;
      r_m1     <= 4'd0;
      r_m0     <= 4'd0;
      r_ore    <= 5'd0;
      r_min    <= 6'd0;
      r_load   <= 1'b0;
      r_stop   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_stop <= 1'b0;
      r_err  <= 1'b0;
      if (w_frame_err) begin
        r_err    <= 1'b1;
        r_pstate <= P_WAIT_CMD;
      end else if (w_byte_valid) begin
        // every rejected byte is consumed and the parser restarts from WAIT_CMD
        r_pstate <= P_WAIT_CMD;
        case (r_pstate)
          P_WAIT_CMD: begin
            if (w_byte == CH_A) begin
              r_pstate <= P_H1;
            end else if (w_byte == CH_S) begin
              r_pstate <= P_END_STOP;
            end else if ((w_byte != CH_CR) && (w_byte != CH_LF)) begin
              r_err <= 1'b1;
            end
          end
          P_H1: begin
            if ((w_byte >= 8'h30) && (w_byte <= 8'h32)) begin
              r_h1     <= w_digit;
              r_pstate <= P_H0;
            end else begin
              r_err <= 1'b1;
            end
          end
          P_H0: begin
            if (w_is_digit && ((r_h1 != 4'd2) || (w_byte <= 8'h33))) begin
              r_h0     <= w_digit;
              r_pstate <= P_COLON;
            end else begin
              r_err <= 1'b1;
            end
          end
          P_COLON: begin
            if (w_byte == CH_COLON) begin
              r_pstate <= P_M1;
            end else begin
              r_err <= 1'b1;
            end
          end
          P_M1: begin
            if ((w_byte >= 8'h30) && (w_byte <= 8'h35)) begin
              r_m1     <= w_digit;
              r_pstate <= P_M0;
            end else begin
              r_err <= 1'b1;
            end
          end
          P_M0: begin
            if (w_is_digit) begin
              r_m0     <= w_digit;
              r_pstate <= P_END_SET;
            end else begin
              r_err <= 1'b1;
            end
          end
          P_END_SET: begin
            if (w_byte == CH_CR) begin
              r_ore  <= w_hour;
              r_min  <= w_minute;
              r_load <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
            if (w_byte == CH_CR) begin
              r_stop <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alarma_cmd.sv
// tb/tb_uart_alarma_cmd.sv - directed self-checking bench for uart_alarma_cmd
module tb_uart_alarma_cmd;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [4:0] ore_setare;
  logic [5:0] minute_setare;
  logic       load;
  logic       stop;
  logic       err;
  logic       busy;

  int n_checks;
  int n_fail;
  int n_load;
  int n_stop;
  int n_err;
  int n_busy;
  int n_multi;
  logic [4:0] q_ore[$];
  logic [5:0] q_min[$];

  uart_alarma_cmd #(.CLKS_PER_BIT(CPB)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .ore_setare    (ore_setare),
    .minute_setare (minute_setare),
    .load          (load),
    .stop          (stop),
    .err           (err),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pulse monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (load === 1'b1) begin
      n_load = n_load + 1;
      q_ore.push_back(ore_setare);
      q_min.push_back(minute_setare);
    end
    if (stop === 1'b1) n_stop = n_stop + 1;
    if (err === 1'b1) n_err = n_err + 1;
    if (busy === 1'b1) n_busy = n_busy + 1;
    if ((int'(load) + int'(stop) + int'(err)) > 1) n_multi = n_multi + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  task automatic clear_counts;
    n_load = 0;
    n_stop = 0;
    n_err  = 0;
    n_busy = 0;
    q_ore.delete();
    q_min.delete();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx    = 1'b1;
    tick(4);
    n_checks++; if (ore_setare !== 5'd0) begin n_fail++; $display("FAIL reset_ore got %0d want 0", ore_setare); end
    n_checks++; if (minute_setare !== 6'd0) begin n_fail++; $display("FAIL reset_min got %0d want 0", minute_setare); end
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", load); end
    n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop got %b want 0", stop); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    tick(10);
  endtask

  task automatic test_back_to_back;
    clear_counts();
    send_str("A23:59");
    send_frame(8'h0D, 1'b1);
    send_str("A00:00");
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_load != 2) begin n_fail++; $display("FAIL b2b_load_count got %0d want 2", n_load); end
    n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL b2b_err_count got %0d want 0", n_err); end
    if (q_ore.size() == 2) begin
      n_checks++; if (q_ore[0] !== 5'd23) begin n_fail++; $display("FAIL b2b_ore0 got %0d want 23", q_ore[0]); end
      n_checks++; if (q_min[0] !== 6'd59) begin n_fail++; $display("FAIL b2b_min0 got %0d want 59", q_min[0]); end
      n_checks++; if (q_ore[1] !== 5'd0) begin n_fail++; $display("FAIL b2b_ore1 got %0d want 0", q_ore[1]); end
      n_checks++; if (q_min[1] !== 6'd0) begin n_fail++; $display("FAIL b2b_min1 got %0d want 0", q_min[1]); end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL b2b_captures got %0d want 2", q_ore.size());
    end
    n_checks++; if (ore_setare !== 5'd0) begin n_fail++; $display("FAIL b2b_hold_ore got %0d want 0", ore_setare); end
    n_checks++; if (minute_setare !== 6'd0) begin n_fail++; $display("FAIL b2b_hold_min got %0d want 0", minute_setare); end
  endtask

  task automatic test_set_basic;
    clear_counts();
    send_str("A07:45");
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_load != 1) begin n_fail++; $display("FAIL set_load_count got %0d want 1", n_load); end
    n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL set_err_count got %0d want 0", n_err); end
    if (q_ore.size() == 1) begin
      n_checks++; if (q_ore[0] !== 5'd7) begin n_fail++; $display("FAIL set_ore_at_load got %0d want 7", q_ore[0]); end
      n_checks++; if (q_min[0] !== 6'd45) begin n_fail++; $display("FAIL set_min_at_load got %0d want 45", q_min[0]); end
    end
    n_checks++; if (ore_setare !== 5'd7) begin n_fail++; $display("FAIL set_ore got %0d want 7", ore_setare); end
    n_checks++; if (minute_setare !== 6'd45) begin n_fail++; $display("FAIL set_min got %0d want 45", minute_setare); end
  endtask

  task automatic test_stop_cmd;
    clear_counts();
    send_frame(8'h53, 1'b1);
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_stop != 1) begin n_fail++; $display("FAIL stop_count got %0d want 1", n_stop); end
    n_checks++; if (n_load != 0) begin n_fail++; $display("FAIL stop_load_count got %0d want 0", n_load); end
    n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL stop_err_count got %0d want 0", n_err); end
    n_checks++; if (ore_setare !== 5'd7) begin n_fail++; $display("FAIL stop_ore got %0d want 7", ore_setare); end
    n_checks++; if (minute_setare !== 6'd45) begin n_fail++; $display("FAIL stop_min got %0d want 45", minute_setare); end
  endtask

  task automatic test_bad_hour;
    clear_counts();
    send_str("A24");
    tick(4);
    n_checks++; if (n_err != 1) begin n_fail++; $display("FAIL badh_err_on_4 got %0d want 1", n_err); end
    send_str(":10");
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_err != 4) begin n_fail++; $display("FAIL badh_err_count got %0d want 4", n_err); end
    n_checks++; if (n_load != 0) begin n_fail++; $display("FAIL badh_load_count got %0d want 0", n_load); end
    n_checks++; if (ore_setare !== 5'd7) begin n_fail++; $display("FAIL badh_ore got %0d want 7", ore_setare); end
    n_checks++; if (minute_setare !== 6'd45) begin n_fail++; $display("FAIL badh_min got %0d want 45", minute_setare); end
  endtask

  task automatic test_glitch;
    clear_counts();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    // busy spans the detect cycle plus CPB/2 cycles up to the false-start check
    n_checks++; if (n_busy != CPB / 2 + 1) begin n_fail++; $display("FAIL glitch_busy_cycles got %0d want %0d", n_busy, CPB / 2 + 1); end
    n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL glitch_err_count got %0d want 0", n_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b want 0", busy); end
  endtask

  task automatic test_framing;
    clear_counts();
    send_str("A1");
    send_frame(8'h32, 1'b0);
    tick(CPB);
    n_checks++; if (n_err != 1) begin n_fail++; $display("FAIL frame_err_pulse got %0d want 1", n_err); end
    send_str("2:30");
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_err != 5) begin n_fail++; $display("FAIL frame_err_count got %0d want 5", n_err); end
    n_checks++; if (n_load != 0) begin n_fail++; $display("FAIL frame_load_count got %0d want 0", n_load); end
    n_checks++; if (ore_setare !== 5'd7) begin n_fail++; $display("FAIL frame_ore got %0d want 7", ore_setare); end
  endtask

  task automatic test_reset_mid;
    clear_counts();
    send_str("A12:");
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(CPB / 2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (ore_setare !== 5'd0) begin n_fail++; $display("FAIL mid_ore got %0d want 0", ore_setare); end
    n_checks++; if (minute_setare !== 6'd0) begin n_fail++; $display("FAIL mid_min got %0d want 0", minute_setare); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_checks++; if ({load, stop, err} !== 3'b000) begin n_fail++; $display("FAIL mid_pulses got %b want 000", {load, stop, err}); end
    tick(3);
    rx = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(20);
    clear_counts();
    send_str("A01:02");
    send_frame(8'h0D, 1'b1);
    tick(20);
    n_checks++; if (n_load != 1) begin n_fail++; $display("FAIL post_load_count got %0d want 1", n_load); end
    n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL post_err_count got %0d want 0", n_err); end
    n_checks++; if (ore_setare !== 5'd1) begin n_fail++; $display("FAIL post_ore got %0d want 1", ore_setare); end
    n_checks++; if (minute_setare !== 6'd2) begin n_fail++; $display("FAIL post_min got %0d want 2", minute_setare); end
  endtask

  task automatic test_exclusive;
    n_checks++; if (n_multi != 0) begin n_fail++; $display("FAIL pulse_exclusive got %0d overlaps want 0", n_multi); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_multi  = 0;
    clear_counts();
    reset = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_back_to_back();
    test_set_basic();
    test_stop_cmd();
    test_bad_hour();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
